// File: rtl/vga_capture_pkg.sv
// Shared 640x480@60 timing constants, FSM encoding and helpers for the VGA receive path.
package vga_capture_pkg;

  localparam int VGA_PIX_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int HCLK_W = 12;
  localparam int LCNT_W = 10;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Half-open window test [lo, hi).
  function automatic logic in_window(input logic [HCLK_W-1:0] v,
                                     input logic [HCLK_W-1:0] lo,
                                     input logic [HCLK_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_capture_edge_sync.sv
// Two-flop synchronizer for an active-low sync pin with a falling-edge pulse.
// Flops reset to 1 so an idle (high) sync line never produces a spurious edge.
module vga_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the pin and keep one cycle of history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel phase/position from h/v sync, verifies line
// and frame timing, and strobes out each active pixel once locked.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SEARCH   | waiting for a v_sync falling edge to start a trial frame
// ACQUIRE  | measuring one frame; all lines and line count must be exact
// LOCKED   | timing verified, active pixels are strobed out
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int PIX_DIV  = VGA_PIX_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic [2:0] vgaRed,
  input  logic [2:0] vgaGreen,
  input  logic [1:0] vgaBlue,
  output logic       pix_valid,
  output logic [7:0] pix_data,
  output logic [9:0] pix_col,
  output logic [9:0] pix_row,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int PIX_SH  = $clog2(PIX_DIV);

  localparam logic [HCLK_W-1:0] LINE_LAST = HCLK_W'(H_TOTAL * PIX_DIV - 1);
  localparam logic [HCLK_W-1:0] H_TMO     = HCLK_W'(H_TOTAL * PIX_DIV + PIX_DIV);
  localparam logic [HCLK_W-1:0] PH_MASK   = HCLK_W'(PIX_DIV - 1);
  localparam logic [HCLK_W-1:0] PH_SAMPLE = HCLK_W'(PIX_DIV / 2);
  localparam logic [HCLK_W-1:0] PX_LO     = HCLK_W'(H_SYNC + H_BP);
  localparam logic [HCLK_W-1:0] PX_HI     = HCLK_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HCLK_W-1:0] LN_LO     = HCLK_W'(V_SYNC + V_BP);
  localparam logic [HCLK_W-1:0] LN_HI     = HCLK_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [LCNT_W-1:0] LN_LAST   = LCNT_W'(V_TOTAL - 1);

  logic              w_h_fall;
  logic              w_v_fall;
  logic [7:0]        r_col_s1;
  logic [7:0]        r_col_s2;
  logic [HCLK_W-1:0] r_hclk;
  logic [HCLK_W-1:0] w_hcnt;
  logic [HCLK_W-1:0] w_pix;
  logic [LCNT_W-1:0] r_lcnt;
  logic [LCNT_W-1:0] w_lcnt;
  logic              r_vpend;
  logic              w_vpend;
  logic              r_hseen;
  logic              w_line_bad;
  logic              w_cnt_ok;
  logic              w_tmo;
  logic              w_active;
  logic              w_strobe;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_frm_ok;
  logic              w_frm_ok_nxt;
  logic              w_err;

  vga_edge_sync u_hsync (.i_clk(clk), .i_rst_n(rst_n), .i_async(h_sync), .o_fall(w_h_fall));
  vga_edge_sync u_vsync (.i_clk(clk), .i_rst_n(rst_n), .i_async(v_sync), .o_fall(w_v_fall));

  // Colour takes the same two-flop path as the syncs so it stays phase-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else begin
      r_col_s1 <= {vgaBlue, vgaGreen, vgaRed};
      r_col_s2 <= r_col_s1;
    end
  end

  // Position of the sample currently at the synchronizer output; a v edge is
  // applied before a same-cycle h edge so that line becomes line 0.
  always_comb begin
    w_hcnt = r_hclk;
    if (w_h_fall)                w_hcnt = '0;
    else if (r_hclk != '1)       w_hcnt = r_hclk + 12'd1;
    w_vpend = r_vpend | w_v_fall;
    w_lcnt  = r_lcnt;
    if (w_h_fall)                w_lcnt = w_vpend ? '0 : r_lcnt + 10'd1;
  end

  assign w_pix      = w_hcnt >> PIX_SH;
  assign w_line_bad = w_h_fall && !(r_hseen && (r_hclk == LINE_LAST));
  assign w_cnt_ok   = (r_lcnt == LN_LAST);
  assign w_tmo      = !w_h_fall && (w_hcnt == H_TMO);
  assign w_active   = ((w_hcnt & PH_MASK) == PH_SAMPLE) &&
                      in_window(w_pix, PX_LO, PX_HI) &&
                      in_window({2'b00, w_lcnt}, LN_LO, LN_HI);
  assign w_strobe   = w_active && (w_state_nxt == ST_LOCKED);

  // Horizontal/vertical position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hclk  <= '0;
      r_lcnt  <= '0;
      r_vpend <= 1'b0;
      r_hseen <= 1'b0;
    end else begin
      r_hclk  <= w_hcnt;
      r_lcnt  <= w_lcnt;
      r_vpend <= w_h_fall ? 1'b0 : w_vpend;
      r_hseen <= r_hseen | w_h_fall;
    end
  end

  // Lock FSM next-state; a bad line in ACQUIRE is only reported at the v edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_frm_ok_nxt = r_frm_ok;
    w_err        = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_v_fall) begin
          w_state_nxt  = ST_ACQUIRE;
          w_frm_ok_nxt = 1'b1;
        end
      end
      ST_ACQUIRE: begin
        if (w_line_bad || w_tmo) w_frm_ok_nxt = 1'b0;
        if (w_v_fall) begin
          if (w_frm_ok_nxt && w_cnt_ok) w_state_nxt = ST_LOCKED;
          else                          w_err       = 1'b1;
          w_frm_ok_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_line_bad || w_tmo || (w_v_fall && !w_cnt_ok)) begin
          w_state_nxt = ST_SEARCH;
          w_err       = 1'b1;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_SEARCH;
      r_frm_ok <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_frm_ok <= w_frm_ok_nxt;
    end
  end

  // Output registers; pixel fields hold their last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_col     <= '0;
      pix_row     <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid   <= w_strobe;
      sync_err    <= w_err;
      frame_start <= w_strobe && (w_pix == PX_LO) && ({2'b00, w_lcnt} == LN_LO);
      if (w_strobe) begin
        pix_data <= r_col_s2;
        pix_col  <= LCNT_W'(w_pix - PX_LO);
        pix_row  <= LCNT_W'({2'b00, w_lcnt} - LN_LO);
      end
    end
  end

  assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a shrunken raster so full frames stay short.
module tb_vga_capture;

  localparam int PD  = 4;
  localparam int HA  = 8;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 1;
  localparam int HT  = HS + HBP + HA + HFP;   // 15 pixels per line
  localparam int VT  = VS + VBP + VA + VFP;   // 8 lines per frame

  logic       clk;
  logic       rst_n;
  logic       h_sync;
  logic       v_sync;
  logic [2:0] vgaRed;
  logic [2:0] vgaGreen;
  logic [1:0] vgaBlue;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [9:0] pix_col;
  logic [9:0] pix_row;
  logic       frame_start;
  logic       locked;
  logic       sync_err;

  vga_capture #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int line_cyc [0:15];
  bit use_a5 = 1'b0;

  function automatic logic [7:0] pat(input int col, input int row, input bit a5);
    if (a5 && col == 0 && row == 0) return 8'hA5;
    return 8'((col + row) & 255);
  endfunction

  // Passive observer: counts events and flags malformed strobes.
  int n_valid = 0, n_fs = 0, n_serr = 0, mon_bad = 0, idx = 0;
  int lock_cyc = -1, fs_cyc = -1, serr_cyc = -1, last_col = -1, last_row = -1;
  bit m_vprev = 1'b1, m_lprev = 1'b0;
  always @(negedge clk) begin
    if (m_vprev && !v_sync) idx = 0;
    m_vprev = v_sync;
    if (frame_start) begin
      n_fs++;
      fs_cyc = cyc;
      if (!pix_valid || idx != 0) mon_bad++;
    end
    if (pix_valid) begin
      n_valid++;
      if (int'(pix_col) != idx % HA || int'(pix_row) != idx / HA ||
          pix_data !== pat(idx % HA, idx / HA, use_a5)) mon_bad++;
      if ((idx == 0) != frame_start) mon_bad++;
      last_col = int'(pix_col);
      last_row = int'(pix_row);
      idx++;
    end
    if ((pix_valid || frame_start) && !locked) mon_bad++;
    if (sync_err) begin
      n_serr++;
      serr_cyc = cyc;
    end
    if (locked && !m_lprev) lock_cyc = cyc;
    m_lprev = locked;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(pix_valid), 0);
    chk({tag, "_data"},  int'(pix_data), 0);
    chk({tag, "_col"},   int'(pix_col), 0);
    chk({tag, "_row"},   int'(pix_row), 0);
    chk({tag, "_fs"},    int'(frame_start), 0);
    chk({tag, "_lock"},  int'(locked), 0);
    chk({tag, "_err"},   int'(sync_err), 0);
  endtask

  // One line of the raster; rst_clk >= 0 pulses rst_n low for one clock there.
  task automatic drive_line(input int line, input int npix, input int rst_clk);
    logic [7:0] d;
    for (int p = 0; p < npix; p++) begin
      for (int c = 0; c < PD; c++) begin
        @(negedge clk);
        if (!rst_n) rst_n = 1'b1;
        if (p == 0 && c == 0) line_cyc[line] = cyc;
        h_sync = (p >= HS);
        v_sync = (line >= VS);
        d = 8'h00;
        if (line >= VS + VBP && line < VS + VBP + VA && p >= HS + HBP && p < HS + HBP + HA)
          d = pat(p - (HS + HBP), line - (VS + VBP), use_a5);
        vgaRed   = d[2:0];
        vgaGreen = d[5:3];
        vgaBlue  = d[7:6];
        if (p * PD + c == rst_clk) begin
          rst_n = 1'b0;
          #1;
          chk_zero("midline_rst");
        end
      end
    end
  endtask

  task automatic drive_frame(input int nlines, input int stretch, input int rst_line, input int rst_clk);
    for (int l = 0; l < nlines; l++)
      drive_line(l, (l == stretch) ? HT + 1 : HT, (l == rst_line) ? rst_clk : -1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_sync = 1'b1;
      v_sync = 1'b1;
      vgaRed = '0; vgaGreen = '0; vgaBlue = '0;
    end
  endtask

  int nv0, nfs0, fstart;

  initial begin
    rst_n = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
    vgaRed = '0; vgaGreen = '0; vgaBlue = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // Two standard frames: lock 3 clk after the second v edge.
    drive_frame(VT, -1, -1, -1);
    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    chk("lock_time", lock_cyc, line_cyc[0] + 3);
    chk("lock_f1", int'(locked), 1);
    chk("count_f1", n_valid - nv0, HA * VA);

    // First active pixel 8'hA5: frame_start with (0,0) at pin + 3 clk.
    use_a5 = 1'b1;
    nv0 = n_valid; nfs0 = n_fs;
    drive_frame(VT, -1, -1, -1);
    use_a5 = 1'b0;
    chk("fs_time", fs_cyc, line_cyc[0] + ((VS + VBP) * HT + HS + HBP) * PD + PD / 2 + 3);
    chk("fs_count", n_fs - nfs0, 1);
    chk("count_f2", n_valid - nv0, HA * VA);
    chk("last_col", last_col, HA - 1);
    chk("last_row", last_row, VA - 1);

    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    chk("count_f3", n_valid - nv0, HA * VA);
    chk("lock_f3", int'(locked), 1);
    chk("no_err_std", n_serr, 0);

    // Line 4 stretched by one pixel: error at the following h edge.
    nv0 = n_valid;
    drive_frame(VT, 4, -1, -1);
    chk("count_stretch", n_valid - nv0, 2 * HA);
    chk("err_stretch_n", n_serr, 1);
    chk("err_stretch_t", serr_cyc, line_cyc[5] + 3);
    chk("lock_stretch", int'(locked), 0);
    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    chk("count_reacq", n_valid - nv0, 0);
    chk("lock_reacq", int'(locked), 0);
    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    chk("count_relock", n_valid - nv0, HA * VA);
    chk("lock_relock", int'(locked), 1);

    // h_sync stuck high after one line: timeout at hclk = HT*PD + PD.
    drive_line(0, HT, -1);
    fstart = line_cyc[0];
    idle(80);
    chk("err_tmo_t", serr_cyc, fstart + HT * PD + PD + 3);
    chk("err_tmo_n", n_serr, 2);
    chk("lock_tmo", int'(locked), 0);

    // Short frame while acquiring: error at the v edge, lock stays low.
    drive_frame(VT - 1, -1, -1, -1);
    drive_frame(VT, -1, -1, -1);
    chk("err_short_t", serr_cyc, line_cyc[0] + 3);
    chk("err_short_n", n_serr, 3);
    chk("lock_short", int'(locked), 0);
    use_a5 = 1'b1;
    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    use_a5 = 1'b0;
    chk("lock_after_short", int'(locked), 1);
    chk("fs_time2", fs_cyc, line_cyc[0] + ((VS + VBP) * HT + HS + HBP) * PD + PD / 2 + 3);
    chk("count_after_short", n_valid - nv0, HA * VA);

    // One-clock reset in the middle of line 5 aborts the frame.
    nv0 = n_valid;
    drive_frame(VT, -1, 5, 10);
    chk("count_rst", n_valid - nv0, 2 * HA);
    chk("lock_rst", int'(locked), 0);
    drive_frame(VT, -1, -1, -1);
    nv0 = n_valid;
    drive_frame(VT, -1, -1, -1);
    chk("lock_final", int'(locked), 1);
    chk("count_final", n_valid - nv0, HA * VA);
    chk("err_final_n", n_serr, 3);
    chk("strobe_integrity", mon_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
